pc_seq: RTL

- Parametrised program-sequencing unit for the single-cycle CPU datapath.
- Owns the program counter and a return-address stack of configurable depth.
- Also handles jump, call/return, stall and a single-level interrupt entry/exit.
- Drives the program-memory address; takes its control signals from the control unit.

---
 rtl/pc_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pc_seq.sv
// Program-sequencing unit: program counter, return-address stack,
// jump/call/return, stall and single-level interrupt entry/exit.
module pc_seq #(
  parameter int AW = 10,
  parameter int DEPTH = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [AW-1:0] IRQ_VEC = AW'(1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_inc,
  input  logic [AW-1:0]              dir_salto,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       reti,
  input  logic                       stall,
  input  logic                       irq,
  output logic [AW-1:0]              pc,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       in_isr,
  output logic                       irq_ack,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;

  logic [AW-1:0]  stack_mem [DEPTH];

  logic [AW-1:0]  pc_q, pc_n;
  logic [SPW-1:0] sp_q, sp_n;
  logic           in_isr_q, in_isr_n;
  logic           ack_q, ack_n;
  logic           ovf_q, ovf_n;
  logic           unf_q, unf_n;

  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [AW-1:0]  wr_data;

  logic           full, empty, take_irq;
  logic [AW-1:0]  pc_inc, pc_seq_next;
  logic [IW-1:0]  top_idx;

  assign full        = (sp_q == SPW'(DEPTH));
  assign empty       = (sp_q == '0);
  assign pc_inc      = pc_q + AW'(1);
  assign pc_seq_next = s_inc ? pc_inc : dir_salto;
  assign top_idx     = IW'(sp_q - SPW'(1));
  assign take_irq    = irq && !in_isr_q && !full;

  // Priority: stall, interrupt entry, pop/reti, push, plain sequencing.
  always_comb begin
    pc_n     = pc_q;
    sp_n     = sp_q;
    in_isr_n = in_isr_q;
    ack_n    = 1'b0;
    ovf_n    = ovf_q;
    unf_n    = unf_q;
    wr_en    = 1'b0;
    wr_idx   = sp_q[IW-1:0];
    wr_data  = pc_inc;

    if (stall) begin
      pc_n = pc_q;
    end else if (take_irq) begin
      // The interrupted instruction was not executed, so its own address is saved.
      wr_en    = 1'b1;
      wr_data  = pc_q;
      sp_n     = sp_q + SPW'(1);
      pc_n     = IRQ_VEC;
      in_isr_n = 1'b1;
      ack_n    = 1'b1;
    end else if (pop || reti) begin
      if (!empty) begin
        pc_n = stack_mem[top_idx];
        sp_n = sp_q - SPW'(1);
      end else begin
        pc_n  = pc_inc;
        unf_n = 1'b1;
      end
      if (reti) begin
        in_isr_n = 1'b0;
      end
    end else if (push) begin
      if (!full) begin
        wr_en = 1'b1;
        sp_n  = sp_q + SPW'(1);
      end else begin
        ovf_n = 1'b1;
      end
      pc_n = pc_seq_next;
    end else begin
      pc_n = pc_seq_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      sp_q     <= '0;
      in_isr_q <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_n;
      sp_q     <= sp_n;
      in_isr_q <= in_isr_n;
      ack_q    <= ack_n;
      ovf_q    <= ovf_n;
      unf_q    <= unf_n;
    end
  end

  // Stack contents are deliberately left untouched by reset; only sp is cleared.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      stack_mem[wr_idx] <= wr_data;
    end
  end

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign in_isr      = in_isr_q;
  assign irq_ack     = ack_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule
